// File: rtl/sdram_auto_refresh.sv
// Periodic AUTO REFRESH engine: after init_done, raises ref_req every
// REF_INTERVAL cycles and, once granted, drives PRECHARGE-ALL / AUTO REFRESH.
// Ports: sclk, snrst (async active-low), init_done, ref_en (grant)
//        -> ref_req, ref_cmd {cs_n,ras_n,cas_n,we_n}, ref_addr, ref_done,
//        ref_overrun (sticky: interval expired with a request still pending).
// Optional: define SDRAM_AREF_TWICE_EN to issue two AUTO REFRESH per grant.
module sdram_auto_refresh #(
    parameter int REF_INTERVAL = 780,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 7
) (
    input  logic        sclk,
    input  logic        snrst,
    input  logic        init_done,
    input  logic        ref_en,
    output logic        ref_req,
    output logic [3:0]  ref_cmd,
    output logic [12:0] ref_addr,
    output logic        ref_done,
    output logic        ref_overrun
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam int MAX_AB = (REF_INTERVAL > T_RP) ? REF_INTERVAL : T_RP;
    localparam int MAXP   = (MAX_AB > T_RFC) ? MAX_AB : T_RFC;
    localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

    // Last value of the wait counter in TRP / TRFC (T-1 cycles each).
    localparam int TRP_LAST  = (T_RP  >= 2) ? T_RP  - 2 : 0;
    localparam int TRFC_LAST = (T_RFC >= 2) ? T_RFC - 2 : 0;

    typedef enum logic [2:0] {
        IDLE, REQ, PRE, TRP, AREF, TRFC, DONE
    } state_t;

    state_t         state;
    state_t         nxt;
    state_t         after_rfc;
    logic [CW-1:0]  icnt;
    logic [CW-1:0]  wcnt;
    logic           tick;
    logic           trp_end;
    logic           trfc_end;

    assign tick     = init_done && (icnt == CW'(REF_INTERVAL - 1));
    assign trp_end  = (wcnt == CW'(TRP_LAST));
    assign trfc_end = (wcnt == CW'(TRFC_LAST));

`ifdef SDRAM_AREF_TWICE_EN
    // Set once the second AUTO REFRESH has been scheduled for this grant.
    logic second;

    always_ff @(posedge sclk or negedge snrst) begin
        if (!snrst) begin
            second <= 1'b0;
        end else if (!init_done || state == PRE) begin
            second <= 1'b0;
        end else if ((state == TRFC || state == AREF) && nxt == AREF) begin
            second <= 1'b1;
        end
    end

    assign after_rfc = second ? DONE : AREF;
`else
    assign after_rfc = DONE;
`endif

    // State register plus interval and wait counters.
    always_ff @(posedge sclk or negedge snrst) begin
        if (!snrst) begin
            state       <= IDLE;
            icnt        <= '0;
            wcnt        <= '0;
            ref_overrun <= 1'b0;
        end else if (!init_done) begin
            state <= IDLE;
            icnt  <= '0;
            wcnt  <= '0;
        end else begin
            state <= nxt;
            icnt  <= tick ? '0 : icnt + 1'b1;
            wcnt  <= (nxt != state) ? '0 : wcnt + 1'b1;
            if (tick && state != IDLE) begin
                ref_overrun <= 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (tick) nxt = REQ;
            REQ:  if (ref_en) nxt = PRE;
            PRE:  nxt = (T_RP > 1) ? TRP : AREF;
            TRP:  if (trp_end) nxt = AREF;
            AREF: nxt = (T_RFC > 1) ? TRFC : after_rfc;
            TRFC: if (trfc_end) nxt = after_rfc;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only.
    always_comb begin
        ref_req  = 1'b0;
        ref_cmd  = CMD_NOP;
        ref_addr = '0;
        ref_done = 1'b0;
        unique case (state)
            REQ: ref_req = 1'b1;
            PRE: begin
                ref_cmd  = CMD_PRE;
                ref_addr = 13'h0400;
            end
            AREF: ref_cmd = CMD_AREF;
            DONE: ref_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_auto_refresh.sv
// Randomized self-checking bench for sdram_auto_refresh.
// Compares every cycle against a timeline reference model.
module tb_sdram_auto_refresh;

    localparam int RI   = 780;
    localparam int TRP  = 2;
    localparam int TRFC = 7;
`ifdef SDRAM_AREF_TWICE_EN
    localparam int NAREF = 2;
`else
    localparam int NAREF = 1;
`endif
    // Sequence position of the DONE cycle (PRECHARGE is position 1).
    localparam int LAST = 1 + TRP + NAREF * TRFC;

    logic        sclk;
    logic        snrst;
    logic        init_done;
    logic        ref_en;
    logic        ref_req;
    logic [3:0]  ref_cmd;
    logic [12:0] ref_addr;
    logic        ref_done;
    logic        ref_overrun;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    sdram_auto_refresh dut (
        .sclk        (sclk),
        .snrst       (snrst),
        .init_done   (init_done),
        .ref_en      (ref_en),
        .ref_req     (ref_req),
        .ref_cmd     (ref_cmd),
        .ref_addr    (ref_addr),
        .ref_done    (ref_done),
        .ref_overrun (ref_overrun)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: n counts enabled cycles, every RI-th is a tick.
    // pos is the cycle index within a granted sequence (0 = none).
    int n     = 0;
    bit m_req = 0;
    int pos   = 0;
    bit m_ovr = 0;

    always @(posedge sclk or negedge snrst) begin
        bit tk, oreq;
        int opos;
        if (!snrst) begin
            n = 0; m_req = 0; pos = 0; m_ovr = 0;
        end else if (!init_done) begin
            n = 0; m_req = 0; pos = 0;
        end else begin
            n++;
            tk   = (n % RI == 0);
            oreq = m_req;
            opos = pos;
            if (pos > 0) pos = (pos == LAST) ? 0 : pos + 1;
            if (tk && (oreq || opos > 0)) m_ovr = 1;
            if (oreq && ref_en) begin
                m_req = 0;
                pos   = 1;
            end else if (tk && !oreq && opos == 0) begin
                m_req = 1;
            end
        end
    end

    function automatic logic [3:0] exp_cmd(input int p);
        if (p == 1) return 4'b0010;
        if (p == 1 + TRP) return 4'b0001;
        if (NAREF == 2 && p == 1 + TRP + TRFC) return 4'b0001;
        return 4'b0111;
    endfunction

    always @(negedge sclk) begin
        if (chk_on) begin
            chk("req",  32'(ref_req), 32'(m_req));
            chk("cmd",  32'(ref_cmd), 32'(exp_cmd(pos)));
            chk("addr", 32'(ref_addr), (pos == 1) ? 32'h400 : 32'h0);
            chk("done", 32'(ref_done), 32'(pos == LAST));
            chk("ovr",  32'(ref_overrun), 32'(m_ovr));
        end
    end

    task automatic wait_req(output int cnt);
        cnt = 0;
        while (!ref_req && cnt < 2000) begin
            @(negedge sclk);
            cnt++;
        end
    endtask

    task automatic grant();
        ref_en = 1'b1;
        @(negedge sclk);
        ref_en = 1'b0;
    endtask

    initial begin
        int cnt;
        snrst = 1'b1; init_done = 1'b0; ref_en = 1'b0;
        #2 snrst = 1'b0;
        #1;
        chk("rst_req", 32'(ref_req), 0);
        chk("rst_cmd", 32'(ref_cmd), 32'h7);
        chk("rst_addr", 32'(ref_addr), 0);
        chk("rst_done", 32'(ref_done), 0);
        chk("rst_ovr", 32'(ref_overrun), 0);
        repeat (2) @(negedge sclk);
        snrst  = 1'b1;
        chk_on = 1;

        // Hold-off with random (ignored) grants.
        repeat (2000) begin
            @(negedge sclk);
            ref_en = 1'($urandom_range(0, 1));
        end
        ref_en = 1'b0;

        // First request latency and sequence timing.
        init_done = 1'b1;
        wait_req(cnt);
        chk("first_req_lat", cnt, RI);
        repeat (3) @(negedge sclk);
        grant();
        chk("seq_pre", 32'(ref_cmd), 32'h2);
        chk("seq_pre_addr", 32'(ref_addr), 32'h400);
        chk("seq_req_low", 32'(ref_req), 0);
        repeat (TRP) @(negedge sclk);
        chk("seq_aref", 32'(ref_cmd), 32'h1);
        if (NAREF == 2) begin
            repeat (TRFC) @(negedge sclk);
            chk("seq_aref2", 32'(ref_cmd), 32'h1);
        end
        repeat (TRFC) @(negedge sclk);
        chk("seq_done", 32'(ref_done), 1);
        @(negedge sclk);
        chk("seq_done_pulse", 32'(ref_done), 0);

        // Overrun: leave the request pending past the next tick.
        wait_req(cnt);
        chk("ovr_req_seen", 32'(ref_req), 1);
        repeat (800) @(negedge sclk);
        chk("ovr_flag", 32'(ref_overrun), 1);
        chk("ovr_req_held", 32'(ref_req), 1);
        grant();
        chk("ovr_grant_pre", 32'(ref_cmd), 32'h2);
        repeat (LAST + 2) @(negedge sclk);

        // Random grants with rare init_done glitches.
        repeat (6000) begin
            @(negedge sclk);
            ref_en    = ($urandom_range(0, 7) == 0);
            init_done = ($urandom_range(0, 1999) != 0);
        end
        ref_en    = 1'b0;
        init_done = 1'b1;

        // Asynchronous reset in the middle of TRFC.
        wait_req(cnt);
        grant();
        repeat (TRP + 2) @(negedge sclk);
        #2 snrst = 1'b0;
        #1;
        chk("arst_cmd", 32'(ref_cmd), 32'h7);
        chk("arst_req", 32'(ref_req), 0);
        chk("arst_done", 32'(ref_done), 0);
        chk("arst_ovr", 32'(ref_overrun), 0);
        @(negedge sclk);
        init_done = 1'b0;
        @(negedge sclk);
        snrst = 1'b1;
        @(negedge sclk);
        init_done = 1'b1;
        wait_req(cnt);
        chk("arst_req_lat", cnt, RI);
        grant();
        repeat (LAST + 5) @(negedge sclk);

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
